px_color_stat: RTL

- Sits directly downstream of the camera capture stage, in parallel with the frame-buffer write port.
- Snoops the RGB332 pixel write stream (address, data, write strobe) in the pclk domain.
- Classifies every pixel as red, green, blue or other, and counts each class per frame.
- At frame end, reports the dominant colour to the project's detection logic.

---
 rtl/px_color_stat.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/px_color_stat.sv
// Per-frame red/green/blue pixel classifier reporting the dominant colour.
// Optional PX_COLOR_STAT_HYST_EN: colour changes only after two matching good frames.
module px_color_stat #(
    parameter int AW      = 15,
    parameter int NPIX    = 19200,
    parameter int MIN_PIX = 1024
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          px_wr,
    input  logic [AW-1:0] mem_px_addr,
    input  logic [7:0]    mem_px_data,
    output logic [1:0]    color,
    output logic          result_valid,
    output logic          frame_err,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACC, EVAL} state_t;

    localparam logic [AW-1:0] LAST  = AW'(NPIX - 1);
    localparam logic [AW-1:0] ADDR1 = AW'(1);
    localparam logic [AW:0]   ONE   = (AW+1)'(1);
    localparam logic [AW:0]   MINC  = (AW+1)'(MIN_PIX);

    state_t        state, state_nx;
    logic [AW-1:0] exp_addr;
    logic          err, fin;
    logic          s1_vld, s1_first, s1_last, s2_last;
    logic [1:0]    s1_cls;
    logic [AW:0]   cr, cg, cb;
    logic [1:0]    cand;
    logic [AW:0]   cmax;
    logic          start, acc_px, first, take, is_last;

    function automatic logic [1:0] classify(input logic [7:0] d);
        logic [2:0] r, g;
        logic [1:0] b;
        r = d[7:5];
        g = d[4:2];
        b = d[1:0];
        if (r >= 3'd4 && g <= 3'd2 && b <= 2'd1)      return 2'd1;
        else if (g >= 3'd4 && r <= 3'd2 && b <= 2'd1) return 2'd2;
        else if (b == 2'd3 && r <= 3'd2 && g <= 3'd2) return 2'd3;
        else                                          return 2'd0;
    endfunction

    // Once the last pixel is sampled, input is ignored until EVAL.
    assign start   = px_wr && mem_px_addr == '0 && (state == IDLE || state == EVAL);
    assign acc_px  = px_wr && state == ACC && !fin;
    assign first   = start || (acc_px && mem_px_addr == '0);
    assign take    = start || acc_px;
    assign is_last = mem_px_addr == LAST;
    assign busy    = state != IDLE;

    always_comb begin
        cand = 2'd0;
        cmax = '0;
        if (cr >= cg && cr >= cb) begin
            cand = 2'd1;
            cmax = cr;
        end else if (cg >= cb) begin
            cand = 2'd2;
            cmax = cg;
        end else begin
            cand = 2'd3;
            cmax = cb;
        end
        if (cmax < MINC) cand = 2'd0;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = ACC;
            ACC:  if (s2_last) state_nx = EVAL;
            EVAL: state_nx = start ? ACC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            exp_addr <= '0;
            err      <= 1'b0;
            fin      <= 1'b0;
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_cls   <= 2'd0;
            s2_last  <= 1'b0;
        end else begin
            state    <= state_nx;
            s1_vld   <= take;
            s1_first <= first;
            s1_last  <= take && is_last;
            s1_cls   <= classify(mem_px_data);
            s2_last  <= s1_vld && s1_last;
            if (first) begin
                exp_addr <= ADDR1;
                err      <= 1'b0;
                fin      <= is_last;
            end else if (acc_px) begin
                exp_addr <= mem_px_addr + ADDR1;
                if (mem_px_addr != exp_addr) err <= 1'b1;
                if (is_last) fin <= 1'b1;
            end else if (state == EVAL) begin
                fin <= 1'b0;
            end
        end
    end

    // Stage 2: the first pixel of a frame reloads the counters.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cr <= '0;
            cg <= '0;
            cb <= '0;
        end else if (s1_vld) begin
            if (s1_first) begin
                cr <= (s1_cls == 2'd1) ? ONE : '0;
                cg <= (s1_cls == 2'd2) ? ONE : '0;
                cb <= (s1_cls == 2'd3) ? ONE : '0;
            end else begin
                if (s1_cls == 2'd1) cr <= cr + ONE;
                if (s1_cls == 2'd2) cg <= cg + ONE;
                if (s1_cls == 2'd3) cb <= cb + ONE;
            end
        end
    end

`ifdef PX_COLOR_STAT_HYST_EN
    logic [1:0] last_cand;
`endif

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            color        <= 2'd0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
`ifdef PX_COLOR_STAT_HYST_EN
            last_cand    <= 2'd0;
`endif
        end else begin
            result_valid <= 1'b0;
            frame_err    <= acc_px && mem_px_addr == '0;
            if (state == EVAL) begin
                if (err) begin
                    frame_err <= 1'b1;
                end else begin
                    result_valid <= 1'b1;
`ifdef PX_COLOR_STAT_HYST_EN
                    if (cand == last_cand) color <= cand;
                    last_cand <= cand;
`else
                    color <= cand;
`endif
                end
            end
        end
    end

endmodule
